jam_cost_server: RTL and testbench

Cost-table responder for the job-assignment engine. It holds the 8x8 worker/job cost matrix and serves the engine's `W`/`J` lookups with a zero-latency `Cost` reply. It also captures the engine's final `MinCost`/`MatchCount` when `Valid` pulses. It sits on the engine's cost interface in place of a behavioural ROM and is loaded over a simple valid/ready stream.

---
 rtl/jam_pkg.sv | 29 ++
 rtl/jam_cost_server_if.sv | 44 ++++
 rtl/jam_cost_mem.sv | 33 +++
 rtl/jam_cost_server.sv | 117 +++++++++++
 tb/tb_jam_cost_server.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jam_pkg
// Purpose  : Shared constants, types and the FSM state encoding for the
//            job-assignment cost server.
// Contents : N, COST_W, IDX_W, SUM_W and derived widths; cost_t; state_t.
// Revision : 1.0  initial release
// ============================================================================
package jam_pkg;

  localparam int N      = 8;            // workers = jobs
  localparam int COST_W = 7;            // width of one cost entry
  localparam int IDX_W  = 3;            // log2(N)
  localparam int SUM_W  = 13;           // 64 * 127 = 8128 fits without overflow
  localparam int PTR_W  = 2 * IDX_W;    // flat {W,J} address width
  localparam int DEPTH  = N * N;
  localparam int MIN_W  = 10;           // engine minimum-cost width
  localparam int CNT_W  = 4;            // engine match-count width

  typedef logic [COST_W-1:0] cost_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : jam_pkg
`default_nettype wire

// File: rtl/jam_cost_server_if.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_if
// Purpose  : Bundles the load stream, the cost lookup port, the result strobe
//            and the status outputs of the cost server.
// Modports : master - engine / loader side
//            slave  - cost server side
// Revision : 1.0  initial release
// ============================================================================
interface jam_cost_if;
  import jam_pkg::*;

  // load stream
  logic               Start;
  logic               LoadValid;
  cost_t              LoadData;
  logic               LoadReady;
  // cost lookup
  logic [IDX_W-1:0]   W;
  logic [IDX_W-1:0]   J;
  cost_t              Cost;
  // engine result strobe
  logic               Valid;
  logic [CNT_W-1:0]   MatchCount;
  logic [MIN_W-1:0]   MinCost;
  // status / captured results
  logic               Ready;
  logic               Done;
  logic [MIN_W-1:0]   ResMinCost;
  logic [CNT_W-1:0]   ResMatchCount;
  logic [SUM_W-1:0]   LoadSum;

  modport master (
    output Start, LoadValid, LoadData, W, J, Valid, MatchCount, MinCost,
    input  LoadReady, Cost, Ready, Done, ResMinCost, ResMatchCount, LoadSum
  );

  modport slave (
    input  Start, LoadValid, LoadData, W, J, Valid, MatchCount, MinCost,
    output LoadReady, Cost, Ready, Done, ResMinCost, ResMatchCount, LoadSum
  );

endinterface : jam_cost_if
`default_nettype wire

// File: rtl/jam_cost_mem.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_mem
// Purpose  : N*N x COST_W register array, one synchronous write port and one
//            combinational read port. Contents are not reset.
// Ports    : CLK            - clock
//            we/waddr/wdata - write port
//            raddr/rdata    - combinational read port
// Revision : 1.0  initial release
// ============================================================================
module jam_cost_mem
  import jam_pkg::*;
(
  input  wire logic              CLK,
  input  wire logic              we,
  input  wire logic [PTR_W-1:0]  waddr,
  input  wire cost_t             wdata,
  input  wire logic [PTR_W-1:0]  raddr,
  output cost_t                  rdata
);

  cost_t r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : jam_cost_mem
`default_nettype wire

// File: rtl/jam_cost_server.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_server
// Purpose  : Cost-table responder for the job-assignment engine. Loads the
//            8x8 cost matrix over a valid/ready stream, serves {W,J} lookups
//            with zero latency and captures the engine's final result.
// Ports    : CLK   - clock, rising edge
//            RST_N - asynchronous active-low reset
//            bus   - jam_cost_if.slave (load stream, lookup, result, status)
// Revision : 1.0  initial release
// ============================================================================
module jam_cost_server
  import jam_pkg::*;
(
  input  wire logic   CLK,
  input  wire logic   RST_N,
  jam_cost_if.slave   bus
);

  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [SUM_W-1:0]   r_load_sum;
  logic [MIN_W-1:0]   r_res_min;
  logic [CNT_W-1:0]   r_res_cnt;

  logic               w_accept;
  logic               w_capture;
  logic               w_load_ready;
  cost_t              w_rdata;

  // Start overrides both a load beat and a result strobe on the same edge.
  assign w_accept  = w_load_ready & bus.LoadValid & ~bus.Start;
  assign w_capture = (r_state != LOAD) & bus.Valid & ~bus.Start;

  jam_cost_mem u_mem (
    .CLK   (CLK),
    .we    (w_accept),
    .waddr (r_ptr),
    .wdata (bus.LoadData),
    .raddr ({bus.W, bus.J}),
    .rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    case (r_state)
      LOAD: begin
        w_load_ready = 1'b1;
        if (w_accept && (r_ptr == c_last_ptr)) begin
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (w_capture) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
    if (bus.Start) begin
      w_state_nxt = LOAD;
    end
  end

  // Load pointer and running checksum; the pointer wraps to 0 naturally
  // after the last entry so a later reload starts clean.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr      <= '0;
      r_load_sum <= '0;
    end else if (bus.Start) begin
      r_ptr      <= '0;
      r_load_sum <= '0;
    end else if (w_accept) begin
      r_ptr      <= r_ptr + 1'b1;
      r_load_sum <= r_load_sum + SUM_W'(bus.LoadData);
    end
  end

  // Captured results survive Start; only reset clears them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res_min <= '0;
      r_res_cnt <= '0;
    end else if (w_capture) begin
      r_res_min <= bus.MinCost;
      r_res_cnt <= bus.MatchCount;
    end
  end

  assign bus.LoadReady     = w_load_ready;
  assign bus.Ready         = (r_state != LOAD);
  assign bus.Done          = (r_state == DONE);
  assign bus.Cost          = (r_state != LOAD) ? w_rdata : '0;
  assign bus.ResMinCost    = r_res_min;
  assign bus.ResMatchCount = r_res_cnt;
  assign bus.LoadSum       = r_load_sum;

endmodule : jam_cost_server
`default_nettype wire

// File: tb/tb_jam_cost_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_cost_server
// Purpose  : Self-checking bench for jam_cost_server with a behavioural
//            reference model of the cost table and result capture.
// Revision : 1.0  initial release
// ============================================================================
module tb_jam_cost_server;
  import jam_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;

  jam_cost_if bus ();

  jam_cost_server dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: table contents, beats taken so far, checksum, results
  bit m_loading;
  int m_cnt;
  int m_sum;
  bit m_done;
  int m_res_min;
  int m_res_cnt;
  int m_mem [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b1;
    m_cnt     = 0;
    m_sum     = 0;
    m_done    = 1'b0;
    m_res_min = 0;
    m_res_cnt = 0;
  endtask

  // Applies the inputs present just before a rising edge to the model.
  task automatic model_edge();
    if (bus.Start) begin
      m_loading = 1'b1;
      m_cnt     = 0;
      m_sum     = 0;
      m_done    = 1'b0;
    end else if (m_loading) begin
      if (bus.LoadValid) begin
        m_mem[m_cnt] = int'(bus.LoadData);
        m_sum       += int'(bus.LoadData);
        m_cnt++;
        if (m_cnt == 64) begin
          m_loading = 1'b0;
          m_cnt     = 0;
        end
      end
    end else if (bus.Valid) begin
      m_res_min = int'(bus.MinCost);
      m_res_cnt = int'(bus.MatchCount);
      m_done    = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    int exp_cost;
    exp_cost = m_loading ? 0 : m_mem[{bus.W, bus.J}];
    check_val({ph, ".LoadReady"},     32'(bus.LoadReady),     32'(m_loading));
    check_val({ph, ".Ready"},         32'(bus.Ready),         32'(!m_loading));
    check_val({ph, ".Done"},          32'(bus.Done),          32'(m_done));
    check_val({ph, ".ResMinCost"},    32'(bus.ResMinCost),    32'(m_res_min));
    check_val({ph, ".ResMatchCount"}, 32'(bus.ResMatchCount), 32'(m_res_cnt));
    check_val({ph, ".LoadSum"},       32'(bus.LoadSum),       32'(m_sum));
    check_val({ph, ".Cost"},          32'(bus.Cost),          32'(exp_cost));
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(ph);
  endtask

  task automatic rand_lookups(input string ph, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      bus.W = IDX_W'($urandom);
      bus.J = IDX_W'($urandom);
      #1;
      check_all(ph);
    end
  endtask

  task automatic load_const(input string ph, input int val);
    for (int i = 0; i < 64; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(val);
      step(ph);
    end
    bus.LoadValid = 1'b0;
  endtask

  initial begin
    int perm [8];
    int best;
    int s;
    int tmp;
    int jx;
    int cyc;

    bus.Start      = 1'b0;
    bus.LoadValid  = 1'b0;
    bus.LoadData   = '0;
    bus.W          = '0;
    bus.J          = '0;
    bus.Valid      = 1'b0;
    bus.MatchCount = '0;
    bus.MinCost    = '0;
    RST_N          = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // ramp load: entry i = i
    for (int i = 0; i < 64; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(i);
      step("ramp");
    end
    bus.LoadValid = 1'b0;
    check_val("ramp_sum", 32'(bus.LoadSum), 32'd2016);
    check_val("ramp_ready", 32'(bus.Ready), 32'd1);
    bus.W = 3'd5;
    bus.J = 3'd3;
    #1;
    check_val("ramp_cost53", 32'(bus.Cost), 32'd43);
    rand_lookups("ramp_lk", 16);

    // capture
    bus.MinCost    = 10'd668;
    bus.MatchCount = 4'd4;
    bus.Valid      = 1'b1;
    step("cap");
    bus.Valid = 1'b0;
    check_val("cap_done", 32'(bus.Done), 32'd1);
    check_val("cap_min", 32'(bus.ResMinCost), 32'd668);
    check_val("cap_cnt", 32'(bus.ResMatchCount), 32'd4);
    rand_lookups("cap_lk", 8);

    // further Valid in DONE overwrites results
    bus.MinCost    = MIN_W'($urandom);
    bus.MatchCount = CNT_W'($urandom);
    bus.Valid      = 1'b1;
    step("recap");
    bus.Valid = 1'b0;
    step("recap_idle");

    // Start colliding with beat 10; old results retained
    bus.Start = 1'b1;
    step("start1");
    bus.Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'($urandom);
      step("col_pre");
    end
    bus.Start    = 1'b1;
    bus.LoadData = COST_W'($urandom);
    step("col");
    bus.Start     = 1'b0;
    bus.LoadValid = 1'b0;
    check_val("col_sum", 32'(bus.LoadSum), 32'd0);
    check_val("col_done", 32'(bus.Done), 32'd0);
    check_val("col_ready", 32'(bus.Ready), 32'd0);
    // Valid during LOAD is ignored
    bus.MinCost = MIN_W'($urandom);
    bus.Valid   = 1'b1;
    step("load_valid");
    bus.Valid = 1'b0;

    // throttled load with random data
    cyc = 0;
    while (m_loading && cyc < 300) begin
      bus.LoadValid = (cyc % 2 == 0);
      bus.LoadData  = COST_W'($urandom);
      step("thr");
      cyc++;
    end
    bus.LoadValid = 1'b0;
    if (m_loading) check_val("thr_timeout", 32'd1, 32'd0);
    rand_lookups("thr_lk", 16);

    // Start together with Valid in SERVE: no capture
    bus.MinCost    = MIN_W'($urandom);
    bus.MatchCount = CNT_W'($urandom);
    bus.Valid      = 1'b1;
    bus.Start      = 1'b1;
    step("sv_col");
    bus.Valid = 1'b0;
    bus.Start = 1'b0;

    // async reset mid-load
    for (int i = 0; i < 20; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'($urandom);
      step("ar_pre");
    end
    bus.LoadValid = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(negedge CLK);
    RST_N = 1'b1;
    load_const("max", 127);
    check_val("max_sum", 32'(bus.LoadSum), 32'd8128);
    rand_lookups("max_lk", 8);

    // end-to-end with a tiny engine over an all-ones matrix
    bus.Start = 1'b1;
    step("e2e_start");
    bus.Start = 1'b0;
    load_const("e2e_load", 1);
    best = 1 << 20;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        jx = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[jx]; perm[jx] = tmp;
      end
      s = 0;
      for (int w = 0; w < 8; w++) begin
        bus.W = IDX_W'(w);
        bus.J = IDX_W'(perm[w]);
        #1;
        s += int'(bus.Cost);
      end
      if (s < best) best = s;
    end
    bus.MinCost    = MIN_W'(best);
    bus.MatchCount = CNT_W'(40320 % 16);
    bus.Valid      = 1'b1;
    step("e2e_cap");
    bus.Valid = 1'b0;
    check_val("e2e_min", 32'(bus.ResMinCost), 32'd8);
    check_val("e2e_cnt", 32'(bus.ResMatchCount), 32'd0);
    check_val("e2e_done", 32'(bus.Done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_jam_cost_server
`default_nettype wire
